coasia_approver: RTL and testbench

Synthesizable responder that drives the slave end of the CoAsia application interface. It samples an applicant request (`mems`, `lang_cer`, `kore_sub`) driven by the master, evaluates it over a fixed number of cycles, and drives a 2-bit `approval` verdict back. It also tracks a running member quota across requests. It is the DUT behind the slave modport, and the UVM master agent drives it.

---
 rtl/coasia_approver.sv | 150 +++++++++++++++
 tb/tb_coasia_approver.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/coasia_approver.sv
// coasia_approver
//
// Slave-side responder for the CoAsia application interface. A request
// (mems != 0) is captured from IDLE, evaluated for EVAL_CYCLES cycles
// using only the captured copies, and a 2-bit verdict is registered onto
// `approval`. The verdict is held until the master releases (mems == 0),
// which returns the block to IDLE. A running member quota is kept in
// `quota_used` and is only consumed by approved requests.
//
// Optional feature macro: COASIA_WAITLIST_EN
//   defined   : a request that would overflow the quota is waitlisted (11)
//   undefined : a request that would overflow the quota is rejected (10)
//
// Handshake: a request is offered by holding mems != 0; the responder
// accepts it on the first IDLE posedge that samples it, answers with a
// non-zero `approval` EVAL_CYCLES edges later, and drops `approval` on the
// first posedge after that which samples mems == 0.
//
// Ports
//   clk        in   1   clock, posedge
//   rst        in   1   asynchronous active-high reset
//   mems       in   3   requested member count, 0 = idle/release
//   lang_cer   in   2   language certificate level
//   kore_sub   in   1   Korean submission present
//   approval   out  2   00 none, 01 approved, 10 rejected, 11 waitlisted
//   quota_used out  QW  members approved since reset
//   state_dbg  out  2   current FSM state (00 IDLE, 01 EVAL, 10 HOLD)
`timescale 1ns/1ps

module coasia_approver #(
  parameter int EVAL_CYCLES = 2,
  parameter int LANG_MIN    = 2,
  parameter int MAX_MEMS    = 4,
  parameter int QUOTA       = 10,
  localparam int QW         = $clog2(QUOTA + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [2:0]    mems,
  input  logic [1:0]    lang_cer,
  input  logic          kore_sub,
  output logic [1:0]    approval,
  output logic [QW-1:0] quota_used,
  output logic [1:0]    state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [1:0] V_NONE     = 2'b00;
  localparam logic [1:0] V_APPROVED = 2'b01;
  localparam logic [1:0] V_REJECTED = 2'b10;
`ifdef COASIA_WAITLIST_EN
  localparam logic [1:0] V_OVERFLOW = 2'b11;
`else
  localparam logic [1:0] V_OVERFLOW = 2'b10;
`endif

  // Sum width covers both the quota counter and a full 3-bit mems so the
  // overflow compare can never be fooled by a wrapped sum.
  localparam int SW = ((QW > 3) ? QW : 3) + 1;

  localparam logic [3:0]    EVAL_LOAD = 4'(EVAL_CYCLES - 1);
  localparam logic [2:0]    MAX_M     = 3'(MAX_MEMS);
  localparam logic [1:0]    LANG_M    = 2'(LANG_MIN);
  localparam logic [SW-1:0] QUOTA_S   = SW'(QUOTA);

  state_t          state;
  logic [3:0]      cnt;
  logic [2:0]      cap_mems;
  logic [1:0]      cap_lang;
  logic            cap_kore;

  logic [SW-1:0]   quota_sum;
  logic            reject;
  logic            overflow;
  logic [1:0]      verdict;
  logic            grant;

  assign state_dbg = state;

  // Verdict from captured copies only, in priority order:
  // eligibility rejection, then quota overflow, then approval.
  always_comb begin
    quota_sum = SW'(quota_used) + SW'(cap_mems);
    reject    = (cap_mems > MAX_M) || (cap_lang < LANG_M) || !cap_kore;
    overflow  = (quota_sum > QUOTA_S);
    verdict   = V_APPROVED;
    grant     = 1'b0;
    if (reject) begin
      verdict = V_REJECTED;
    end else if (overflow) begin
      verdict = V_OVERFLOW;
    end else begin
      verdict = V_APPROVED;
      grant   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      approval   <= V_NONE;
      quota_used <= '0;
      cnt        <= '0;
      cap_mems   <= '0;
      cap_lang   <= '0;
      cap_kore   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mems != 3'd0) begin
            cap_mems <= mems;
            cap_lang <= lang_cer;
            cap_kore <= kore_sub;
            cnt      <= EVAL_LOAD;
            state    <= EVAL;
          end
        end
        EVAL: begin
          // Live inputs are deliberately not looked at here; an early
          // release still lets the verdict be issued.
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            approval <= verdict;
            if (grant) begin
              quota_used <= quota_sum[QW-1:0];
            end
            state <= HOLD;
          end
        end
        HOLD: begin
          if (mems == 3'd0) begin
            approval <= V_NONE;
            state    <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          approval <= V_NONE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_coasia_approver.sv
`timescale 1ns/1ps

module tb_coasia_approver;

  localparam int EVAL_CYCLES = 2;
  localparam int LANG_MIN    = 2;
  localparam int MAX_MEMS    = 4;
  localparam int QUOTA       = 10;
  localparam int QW          = $clog2(QUOTA + 1);

  localparam logic [1:0] APP = 2'b01;
  localparam logic [1:0] REJ = 2'b10;
`ifdef COASIA_WAITLIST_EN
  localparam logic [1:0] OVF = 2'b11;
`else
  localparam logic [1:0] OVF = 2'b10;
`endif

  // ---------------- clock / reset ----------------
  logic          clk;
  logic          rst;
  logic [2:0]    mems;
  logic [1:0]    lang_cer;
  logic          kore_sub;
  logic [1:0]    approval;
  logic [QW-1:0] quota_used;
  logic [1:0]    state_dbg;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  coasia_approver #(
    .EVAL_CYCLES(EVAL_CYCLES),
    .LANG_MIN   (LANG_MIN),
    .MAX_MEMS   (MAX_MEMS),
    .QUOTA      (QUOTA)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mems      (mems),
    .lang_cer  (lang_cer),
    .kore_sub  (kore_sub),
    .approval  (approval),
    .quota_used(quota_used),
    .state_dbg (state_dbg)
  );

  // ---------------- counters / check ----------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Transaction view: at most one request is in flight, so its verdict and
  // quota effect can be decided the moment it is accepted, and it is then
  // scheduled to appear EVAL_CYCLES edges later and to disappear on the
  // first later edge that sees a release.
  int         m_edge  = 0;
  int         m_due   = 0;
  int         m_quota = 0;
  int         m_add   = 0;
  bit         m_busy  = 1'b0;
  logic [1:0] m_appr  = 2'b00;
  logic [1:0] m_pend  = 2'b00;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy  = 1'b0;
      m_appr  = 2'b00;
      m_quota = 0;
      m_edge  = 0;
    end else begin
      m_edge++;
      if (!m_busy) begin
        if (int'(mems) != 0) begin
          m_busy = 1'b1;
          m_due  = m_edge + EVAL_CYCLES;
          if (int'(mems) > MAX_MEMS || int'(lang_cer) < LANG_MIN || !kore_sub) begin
            m_pend = REJ;
            m_add  = 0;
          end else if (m_quota + int'(mems) > QUOTA) begin
            m_pend = OVF;
            m_add  = 0;
          end else begin
            m_pend = APP;
            m_add  = int'(mems);
          end
        end
      end else if (m_edge == m_due) begin
        m_appr  = m_pend;
        m_quota = m_quota + m_add;
      end else if (m_edge > m_due && int'(mems) == 0) begin
        m_appr = 2'b00;
        m_busy = 1'b0;
      end
    end
  end

  // Scoreboard compare on the falling edge, away from the active edge.
  always @(negedge clk) begin
    check("approval", int'(approval), int'(m_appr));
    check("quota_used", int'(quota_used), m_quota);
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] m, input logic [1:0] l, input logic k);
    mems     = m;
    lang_cer = l;
    kore_sub = k;
  endtask

  task automatic do_reset(input string name);
    rst = 1'b1;
    drive(3'd0, 2'd0, 1'b0);
    #1;
    check({name, "_appr"}, int'(approval), 0);
    check({name, "_quota"}, int'(quota_used), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Full request: latency check, verdict, quota, then release.
  task automatic run_req(input string name, input logic [2:0] m, input logic [1:0] l,
                         input logic k, input logic [1:0] ev, input int eq);
    drive(m, l, k);
    tick(EVAL_CYCLES);
    check({name, "_pre"}, int'(approval), 0);
    tick(1);
    check({name, "_v"}, int'(approval), int'(ev));
    check({name, "_q"}, int'(quota_used), eq);
    drive(3'd0, l, k);
    tick(1);
    check({name, "_rel"}, int'(approval), 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1;
    drive(3'd0, 2'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_appr", int'(approval), 0);
    check("reset_quota", int'(quota_used), 0);

    tick(20);
    check("idle_appr", int'(approval), 0);
    check("idle_quota", int'(quota_used), 0);

    run_req("basic", 3'd3, 2'd2, 1'b1, APP, 3);

    run_req("rej_mems", 3'd5, 2'd3, 1'b1, REJ, 3);
    run_req("rej_lang", 3'd3, 2'd1, 1'b1, REJ, 3);
    run_req("rej_kore", 3'd3, 2'd2, 1'b0, REJ, 3);

    do_reset("rst_a");
    run_req("q4a", 3'd4, 2'd2, 1'b1, APP, 4);
    run_req("q4b", 3'd4, 2'd3, 1'b1, APP, 8);
    run_req("fill", 3'd2, 2'd2, 1'b1, APP, 10);
    run_req("ovf", 3'd1, 2'd2, 1'b1, OVF, 10);

    // Release and input changes during EVAL do not disturb the request.
    do_reset("rst_b");
    drive(3'd2, 2'd2, 1'b1);
    tick(1);
    drive(3'd0, 2'd0, 1'b0);
    tick(EVAL_CYCLES - 1);
    check("erel_pre", int'(approval), 0);
    tick(1);
    check("erel_v", int'(approval), int'(APP));
    check("erel_q", int'(quota_used), 2);
    tick(1);
    check("erel_clr", int'(approval), 0);

    // Reset mid-EVAL: pending approval consumes nothing.
    drive(3'd3, 2'd2, 1'b1);
    tick(2);
    do_reset("rst_eval");

    // Reset mid-HOLD after an approval of 4.
    drive(3'd4, 2'd2, 1'b1);
    tick(1 + EVAL_CYCLES);
    check("hold_v", int'(approval), int'(APP));
    check("hold_q", int'(quota_used), 4);
    #2;
    do_reset("rst_hold");
    run_req("after_rst", 3'd4, 2'd2, 1'b1, APP, 4);

    // Back-to-back: held request is not recaptured.
    drive(3'd2, 2'd2, 1'b1);
    tick(1 + EVAL_CYCLES);
    check("b2b1_v", int'(approval), int'(APP));
    check("b2b1_q", int'(quota_used), 6);
    drive(3'd3, 2'd0, 1'b0);
    tick(5);
    check("b2b_hold_v", int'(approval), int'(APP));
    check("b2b_hold_q", int'(quota_used), 6);
    drive(3'd0, 2'd0, 1'b0);
    tick(1);
    check("b2b_rel", int'(approval), 0);
    drive(3'd1, 2'd2, 1'b1);
    tick(1 + EVAL_CYCLES);
    check("b2b2_v", int'(approval), int'(APP));
    check("b2b2_q", int'(quota_used), 7);
    drive(3'd0, 2'd0, 1'b0);
    tick(2);
    check("end_appr", int'(approval), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
